// File: rtl/inst_seq.sv
// inst_seq: multi-word instruction fetch/decode/execute sequencer.
// Fetches 1-3 instruction words into IR1..IR3, dispatches on the instruction
// class, runs the execute or stack/memory micro-sequence, then retires.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   run               : permits a new fetch from IF1
//   mem_rdy           : memory access completes this cycle
//   ir1_len, kind     : length/class decoded from IR1, sampled in D1
//   state             : current sequencer state
//   mem_req, mem_we   : memory request and write qualifier (state decode)
//   ir_load           : one-hot IR1/IR2/IR3 load strobe (on fetch completion)
//   ip_inc            : instruction pointer increment (on fetch completion)
//   sp_inc, sp_dec    : stack pointer adjust (state decode)
//   exe_en            : execute enable, suppressed for illegal classes
//   inst_done         : instruction retires this cycle
//   illegal           : executing an illegal instruction class
//   retired           : wrapping retired-instruction count
module inst_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [1:0]  ir1_len,
  input  logic [2:0]  kind,
  output logic [3:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  ir_load,
  output logic        ip_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        exe_en,
  output logic        inst_done,
  output logic        illegal,
  output logic [15:0] retired
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned LEN_W   = 2;
  localparam int unsigned KIND_W  = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [STATE_W-1:0] ST_IF1   = 4'd0;
  localparam logic [STATE_W-1:0] ST_D1    = 4'd1;
  localparam logic [STATE_W-1:0] ST_IF2   = 4'd2;
  localparam logic [STATE_W-1:0] ST_D2    = 4'd3;
  localparam logic [STATE_W-1:0] ST_IF3   = 4'd4;
  localparam logic [STATE_W-1:0] ST_D3    = 4'd5;
  localparam logic [STATE_W-1:0] ST_EXE   = 4'd6;
  localparam logic [STATE_W-1:0] ST_PUSH1 = 4'd7;
  localparam logic [STATE_W-1:0] ST_PUSH2 = 4'd8;
  localparam logic [STATE_W-1:0] ST_POP1  = 4'd9;
  localparam logic [STATE_W-1:0] ST_POP2  = 4'd10;
  localparam logic [STATE_W-1:0] ST_RD    = 4'd11;
  localparam logic [STATE_W-1:0] ST_WR    = 4'd12;

  localparam logic [KIND_W-1:0] KIND_EXE  = 3'd0;
  localparam logic [KIND_W-1:0] KIND_PUSH = 3'd1;
  localparam logic [KIND_W-1:0] KIND_POP  = 3'd2;
  localparam logic [KIND_W-1:0] KIND_RD   = 3'd3;
  localparam logic [KIND_W-1:0] KIND_WR   = 3'd4;

  logic [STATE_W-1:0] state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [KIND_W-1:0]  kind_q, kind_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               kind_bad;

  // Class-to-first-execution-state map; illegal classes run a dead EXE cycle.
  function automatic logic [STATE_W-1:0] dispatch(input logic [KIND_W-1:0] k);
    case (k)
      KIND_EXE:  dispatch = ST_EXE;
      KIND_PUSH: dispatch = ST_PUSH1;
      KIND_POP:  dispatch = ST_POP1;
      KIND_RD:   dispatch = ST_RD;
      KIND_WR:   dispatch = ST_WR;
      default:   dispatch = ST_EXE;
    endcase
  endfunction

  assign kind_bad = (kind_q > KIND_WR);

  // Next state, latched decode fields and all strobes.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    kind_d    = kind_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 3'b000;
    ip_inc    = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    exe_en    = 1'b0;
    inst_done = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IF1: begin
        // rst_n gating keeps the request low while reset is held.
        mem_req = run && rst_n;
        if (run && mem_rdy && rst_n) begin
          state_d = ST_D1;
          ir_load = 3'b001;
          ip_inc  = 1'b1;
        end
      end
      ST_D1: begin
        // Decision uses the value being latched; it is identical to len_q next cycle.
        len_d  = ir1_len;
        kind_d = kind;
        if (ir1_len >= 2'd2) state_d = ST_IF2;
        else                 state_d = dispatch(kind);
      end
      ST_IF2: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          state_d = ST_D2;
          ir_load = 3'b010;
          ip_inc  = 1'b1;
        end
      end
      ST_D2: begin
        if (len_q == 2'd3) state_d = ST_IF3;
        else               state_d = dispatch(kind_q);
      end
      ST_IF3: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          state_d = ST_D3;
          ir_load = 3'b100;
          ip_inc  = 1'b1;
        end
      end
      ST_D3: state_d = dispatch(kind_q);
      ST_EXE: begin
        exe_en    = !kind_bad;
        illegal   = kind_bad;
        inst_done = 1'b1;
        state_d   = ST_IF1;
      end
      ST_PUSH1: begin
        sp_dec  = 1'b1;
        state_d = ST_PUSH2;
      end
      ST_PUSH2: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_rdy) begin
          inst_done = 1'b1;
          state_d   = ST_IF1;
        end
      end
      ST_POP1: begin
        mem_req = 1'b1;
        if (mem_rdy) state_d = ST_POP2;
      end
      ST_POP2: begin
        sp_inc    = 1'b1;
        inst_done = 1'b1;
        state_d   = ST_IF1;
      end
      ST_RD: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          inst_done = 1'b1;
          state_d   = ST_IF1;
        end
      end
      ST_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_rdy) begin
          inst_done = 1'b1;
          state_d   = ST_IF1;
        end
      end
      default: state_d = ST_IF1;
    endcase
    retired_d = retired_q + CNT_W'(inst_done);
  end

  // State, latched decode fields and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IF1;
      len_q     <= '0;
      kind_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      kind_q    <= kind_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_inst_seq.sv
// tb_inst_seq: directed self-checking bench for inst_seq.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        mem_rdy;
  logic [1:0]  ir1_len;
  logic [2:0]  kind;
  logic [3:0]  state;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  ir_load;
  logic        ip_inc;
  logic        sp_inc;
  logic        sp_dec;
  logic        exe_en;
  logic        inst_done;
  logic        illegal;
  logic [15:0] retired;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] ST_IF1   = 4'd0;
  localparam logic [3:0] ST_D1    = 4'd1;
  localparam logic [3:0] ST_IF2   = 4'd2;
  localparam logic [3:0] ST_D2    = 4'd3;
  localparam logic [3:0] ST_IF3   = 4'd4;
  localparam logic [3:0] ST_D3    = 4'd5;
  localparam logic [3:0] ST_EXE   = 4'd6;
  localparam logic [3:0] ST_PUSH1 = 4'd7;
  localparam logic [3:0] ST_PUSH2 = 4'd8;
  localparam logic [3:0] ST_POP1  = 4'd9;
  localparam logic [3:0] ST_POP2  = 4'd10;
  localparam logic [3:0] ST_RD    = 4'd11;
  localparam logic [3:0] ST_WR    = 4'd12;

  // Flag order: mem_req, mem_we, ir_load[2:0], ip_inc, sp_inc, sp_dec, exe_en, inst_done, illegal
  localparam logic [10:0] F_NONE   = 11'b0_0_000_0_0_0_0_0_0;
  localparam logic [10:0] F_FETCH1 = 11'b1_0_001_1_0_0_0_0_0;
  localparam logic [10:0] F_FETCH2 = 11'b1_0_010_1_0_0_0_0_0;
  localparam logic [10:0] F_FETCH3 = 11'b1_0_100_1_0_0_0_0_0;
  localparam logic [10:0] F_EXE    = 11'b0_0_000_0_0_0_1_1_0;
  localparam logic [10:0] F_ILL    = 11'b0_0_000_0_0_0_0_1_1;
  localparam logic [10:0] F_RDW    = 11'b1_0_000_0_0_0_0_0_0;
  localparam logic [10:0] F_RDD    = 11'b1_0_000_0_0_0_0_1_0;
  localparam logic [10:0] F_WRW    = 11'b1_1_000_0_0_0_0_0_0;
  localparam logic [10:0] F_WRD    = 11'b1_1_000_0_0_0_0_1_0;
  localparam logic [10:0] F_SPD    = 11'b0_0_000_0_0_1_0_0_0;
  localparam logic [10:0] F_SPI    = 11'b0_0_000_0_1_0_0_1_0;

  inst_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem_rdy   (mem_rdy),
    .ir1_len   (ir1_len),
    .kind      (kind),
    .state     (state),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_load   (ir_load),
    .ip_inc    (ip_inc),
    .sp_inc    (sp_inc),
    .sp_dec    (sp_dec),
    .exe_en    (exe_en),
    .inst_done (inst_done),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check state and strobes.
  task automatic step(input string tag, input logic r, input logic rdy,
                      input logic [1:0] len, input logic [2:0] k,
                      input logic [3:0] st, input logic [10:0] fl);
    @(negedge clk);
    run     = r;
    mem_rdy = rdy;
    ir1_len = len;
    kind    = k;
    #1;
    chk(tag, {17'd0, state, mem_req, mem_we, ir_load, ip_inc, sp_inc, sp_dec,
              exe_en, inst_done, illegal},
             {17'd0, st, fl});
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    mem_rdy = 1'b0;
    ir1_len = 2'd0;
    kind    = 3'd0;

    // Reset state; run and mem_rdy high must not raise mem_req under reset.
    step("rst_idle", 1'b0, 1'b0, 2'd0, 3'd0, ST_IF1, F_NONE);
    step("rst_run",  1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("rst_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    run     = 1'b0;
    mem_rdy = 1'b0;

    // Single-word EXE loop: IF1, D1, EXE repeating.
    for (int i = 0; i < 9; i++) begin
      case (i % 3)
        0:       step("loop_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
        1:       step("loop_d1",  1'b1, 1'b1, 2'd1, 3'd0, ST_D1,  F_NONE);
        default: step("loop_exe", 1'b1, 1'b1, 2'd1, 3'd0, ST_EXE, F_EXE);
      endcase
    end
    step("loop_idle", 1'b0, 1'b0, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("loop_retired", 32'(retired), 32'd3);

    // Three-word WR; inputs outside D1 are garbage to prove latching.
    step("wr_if1", 1'b1, 1'b1, 2'd1, 3'd6, ST_IF1, F_FETCH1);
    step("wr_d1",  1'b1, 1'b1, 2'd3, 3'd4, ST_D1,  F_NONE);
    step("wr_if2", 1'b1, 1'b1, 2'd1, 3'd6, ST_IF2, F_FETCH2);
    step("wr_d2",  1'b1, 1'b1, 2'd0, 3'd6, ST_D2,  F_NONE);
    step("wr_if3", 1'b1, 1'b1, 2'd0, 3'd6, ST_IF3, F_FETCH3);
    step("wr_d3",  1'b1, 1'b1, 2'd0, 3'd6, ST_D3,  F_NONE);
    step("wr_wr",  1'b1, 1'b1, 2'd0, 3'd6, ST_WR,  F_WRD);
    step("wr_idle", 1'b0, 1'b0, 2'd0, 3'd0, ST_IF1, F_NONE);
    chk("wr_retired", 32'(retired), 32'd4);

    // PUSH with a four-cycle memory access.
    step("push_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1,   F_FETCH1);
    step("push_d1",  1'b1, 1'b0, 2'd1, 3'd1, ST_D1,    F_NONE);
    step("push_1",   1'b1, 1'b0, 2'd1, 3'd0, ST_PUSH1, F_SPD);
    for (int i = 0; i < 3; i++)
      step("push_2_wait", 1'b1, 1'b0, 2'd1, 3'd0, ST_PUSH2, F_WRW);
    step("push_2_done", 1'b1, 1'b1, 2'd1, 3'd0, ST_PUSH2, F_WRD);

    // POP with a four-cycle memory access.
    step("pop_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("pop_d1",  1'b1, 1'b0, 2'd1, 3'd2, ST_D1,  F_NONE);
    for (int i = 0; i < 3; i++)
      step("pop_1_wait", 1'b1, 1'b0, 2'd1, 3'd0, ST_POP1, F_RDW);
    step("pop_1_rdy", 1'b1, 1'b1, 2'd1, 3'd0, ST_POP1, F_RDW);
    step("pop_2",     1'b1, 1'b0, 2'd1, 3'd0, ST_POP2, F_SPI);
    step("pop_idle",  1'b0, 1'b0, 2'd1, 3'd0, ST_IF1,  F_NONE);
    chk("pushpop_retired", 32'(retired), 32'd6);

    // Illegal classes still retire, without exe_en; length 0 acts as 1.
    step("ill6_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("ill6_d1",  1'b1, 1'b1, 2'd1, 3'd6, ST_D1,  F_NONE);
    step("ill6_exe", 1'b1, 1'b1, 2'd1, 3'd0, ST_EXE, F_ILL);
    step("ill7_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("ill7_d1",  1'b1, 1'b1, 2'd0, 3'd7, ST_D1,  F_NONE);
    step("ill7_exe", 1'b1, 1'b1, 2'd1, 3'd0, ST_EXE, F_ILL);

    // Two-word RD; D2 inputs differ from latched values.
    step("rd2_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("rd2_d1",  1'b1, 1'b1, 2'd2, 3'd3, ST_D1,  F_NONE);
    step("rd2_if2", 1'b1, 1'b1, 2'd3, 3'd4, ST_IF2, F_FETCH2);
    step("rd2_d2",  1'b1, 1'b1, 2'd3, 3'd4, ST_D2,  F_NONE);
    step("rd2_rd",  1'b1, 1'b1, 2'd3, 3'd4, ST_RD,  F_RDD);

    // run drops mid-instruction: RD completes, then IF1 idles.
    step("stop_if1",  1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("stop_d1",   1'b0, 1'b0, 2'd1, 3'd3, ST_D1,  F_NONE);
    step("stop_rdw",  1'b0, 1'b0, 2'd1, 3'd0, ST_RD,  F_RDW);
    step("stop_rdd",  1'b0, 1'b1, 2'd1, 3'd0, ST_RD,  F_RDD);
    step("stop_idle", 1'b0, 1'b1, 2'd1, 3'd0, ST_IF1, F_NONE);
    step("stop_hold", 1'b0, 1'b1, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("stop_retired", 32'(retired), 32'd10);

    // Counter wrap: preload the all-ones value, then retire one more.
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    step("wrap_pre", 1'b0, 1'b0, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("wrap_preload", 32'(retired), 32'h0000FFFF);
    step("wrap_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("wrap_d1",  1'b1, 1'b1, 2'd1, 3'd0, ST_D1,  F_NONE);
    step("wrap_exe", 1'b1, 1'b1, 2'd1, 3'd0, ST_EXE, F_EXE);
    step("wrap_idle", 1'b0, 1'b0, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("wrap_retired", 32'(retired), 32'd0);

    // Reset during a pending RD abandons it without retiring.
    step("rrst_if1", 1'b1, 1'b1, 2'd1, 3'd0, ST_IF1, F_FETCH1);
    step("rrst_d1",  1'b1, 1'b0, 2'd1, 3'd3, ST_D1,  F_NONE);
    step("rrst_rdw", 1'b1, 1'b0, 2'd1, 3'd0, ST_RD,  F_RDW);
    @(negedge clk);
    mem_rdy = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rrst_state",   32'(state),     32'(ST_IF1));
    chk("rrst_mem_req", 32'(mem_req),   32'd0);
    chk("rrst_done",    32'(inst_done), 32'd0);
    chk("rrst_retired", 32'(retired),   32'd0);
    @(negedge clk);
    chk("rrst_hold_retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    run   = 1'b0;
    step("rrst_idle1", 1'b0, 1'b1, 2'd1, 3'd0, ST_IF1, F_NONE);
    step("rrst_idle2", 1'b0, 1'b1, 2'd1, 3'd0, ST_IF1, F_NONE);
    chk("rrst_final_retired", 32'(retired), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_seq.md
INST_SEQ -- requirements
Module: inst_seq

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: run  input  1  permits a new instruction fetch from IF1.
REQ-004 SHALL have port: mem_rdy  input  1  memory access completes this cycle; ignored when mem_req=0.
REQ-005 SHALL have port: ir1_len  input  2  instruction length in words, decoded from IR1, valid in D1.
REQ-006 SHALL have port: kind  input  3  instruction class, valid in D1: 0 EXE, 1 PUSH, 2 POP, 3 RD, 4 WR, 5-7 illegal.
REQ-007 SHALL have port: state  output  4  current inst_state_e value from common_pkg.
REQ-008 SHALL have port: mem_req  output  1  memory access request.
REQ-009 SHALL have port: mem_we  output  1  memory write qualifier, valid with mem_req.
REQ-010 SHALL have port: ir_load  output  3  one-hot load strobe for IR1/IR2/IR3.
REQ-011 SHALL have ports: ip_inc, sp_inc, sp_dec, exe_en, inst_done, illegal  output  1 each  single-cycle strobes.
REQ-012 SHALL have port: retired  output  16  retired-instruction count.

Function
REQ-013 SHALL hold state in one register; mem_req, mem_we, exe_en, sp_inc, sp_dec decoded from state only (Moore).
REQ-014 SHALL drive ir_load, ip_inc, inst_done as Mealy strobes: asserted only on the cycle where the completing condition holds.
REQ-015 IF1: mem_req=run; on run&&mem_rdy -> D1 with ir_load=3'b001, ip_inc=1; otherwise stay IF1.
REQ-016 D1: SHALL latch ir1_len and kind into internal registers; later states use latched values only.
REQ-017 ir1_len 0 SHALL be treated as 1; ir1_len 3 means three words.
REQ-018 D1: latched len>=2 -> IF2, else dispatch.
REQ-019 IF2: mem_req=1; on mem_rdy -> D2 with ir_load=3'b010, ip_inc=1. D2: len==3 -> IF3, else dispatch.
REQ-020 IF3: mem_req=1; on mem_rdy -> D3 with ir_load=3'b100, ip_inc=1. D3: dispatch.
REQ-021 Dispatch SHALL go to: kind 0 -> EXE; 1 -> PUSH1; 2 -> POP1; 3 -> RD; 4 -> WR; 5-7 -> EXE with illegal=1 for that cycle.
REQ-022 EXE: exe_en=1 (suppressed for illegal kind), one cycle, -> IF1 with inst_done=1.
REQ-023 PUSH1: sp_dec=1, one cycle -> PUSH2. PUSH2: mem_req=1, mem_we=1; on mem_rdy -> IF1 with inst_done=1.
REQ-024 POP1: mem_req=1, mem_we=0; on mem_rdy -> POP2. POP2: sp_inc=1, one cycle -> IF1 with inst_done=1.
REQ-025 RD: mem_req=1, mem_we=0; WR: mem_req=1, mem_we=1; on mem_rdy -> IF1 with inst_done=1.
REQ-026 Memory states SHALL wait indefinitely with mem_req held high until mem_rdy.
REQ-027 retired SHALL increment by 1 on every inst_done, wrapping 16'hFFFF -> 16'h0000.
REQ-028 run deasserted mid-instruction SHALL NOT abort; sequence completes, then holds in IF1 with mem_req=0.
REQ-029 Unused state encodings SHALL return to IF1 on the next clock without strobes.
REQ-030 At most one of ir_load bits, and never both sp_inc and sp_dec, SHALL be asserted in any cycle.

Reset
REQ-031 rst_n low SHALL immediately force state=IF1, retired=0, latched len/kind=0, all strobes and mem_req/mem_we low (mem_req rises after release only if run=1).
REQ-032 Reset asserted mid-instruction (any state, including mem_req pending) SHALL abandon it without inst_done or retired update.

Verification
REQ-033 run=1, mem_rdy=1 constantly, ir1_len=1, kind=0 -> state IF1,D1,EXE,IF1 repeating; inst_done every 3rd cycle; retired=3 after 9 cycles.
REQ-034 ir1_len=3, kind=4, mem_rdy=1 -> IF1,D1,IF2,D2,IF3,D3,WR,IF1; ir_load 001,010,100 in order; ip_inc 3 times; mem_we=1 only in WR.
REQ-035 kind=1 then kind=2, mem_rdy delayed 4 cycles per access -> PUSH1 sp_dec once, PUSH2 holds mem_req 4 cycles; POP1 holds 4 cycles, POP2 sp_inc once.
REQ-036 kind=6 -> D1->EXE with illegal=1, exe_en=0, inst_done=1, retired increments.
REQ-037 Preload retired via 65535 EXE instructions, one more -> retired=16'h0000.
REQ-038 rst_n pulsed low during RD with mem_rdy=0 -> state=IF1, retired unchanged at 0, no inst_done; run=0 afterward -> mem_req stays 0.
